// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and load/store
// requests onto a single-port, byte-wide RAM with one-cycle read latency.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  input  logic        flush,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        owner_mem, owner_mem_next;
  logic [2:0]  cnt, cnt_next;
  logic [2:0]  len, len_next;
  logic [31:0] base, base_next;
  logic [31:0] wdata_q, wdata_next;
  logic [31:0] data_q, data_next;
  logic        if_done_q, if_done_next;
  logic        mem_done_q, mem_done_next;
  logic [31:0] if_inst_q, if_inst_next;
  logic [31:0] mem_rdata_q, mem_rdata_next;
  logic        active;

  function automatic logic [2:0] len_of(input logic [1:0] l);
    case (l)
      2'd0:    len_of = 3'd1;
      2'd1:    len_of = 3'd2;
      default: len_of = 3'd4;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner_mem   <= 1'b0;
      cnt         <= 3'd0;
      len         <= 3'd0;
      base        <= 32'd0;
      wdata_q     <= 32'd0;
      data_q      <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state       <= state_next;
      owner_mem   <= owner_mem_next;
      cnt         <= cnt_next;
      len         <= len_next;
      base        <= base_next;
      wdata_q     <= wdata_next;
      data_q      <= data_next;
      if_done_q   <= if_done_next;
      mem_done_q  <= mem_done_next;
      if_inst_q   <= if_inst_next;
      mem_rdata_q <= mem_rdata_next;
    end
  end

  always_comb begin
    state_next     = state;
    owner_mem_next = owner_mem;
    cnt_next       = cnt;
    len_next       = len;
    base_next      = base;
    wdata_next     = wdata_q;
    data_next      = data_q;
    if_done_next   = 1'b0;
    mem_done_next  = 1'b0;
    if_inst_next   = if_inst_q;
    mem_rdata_next = mem_rdata_q;
    ram_addr       = 32'd0;
    ram_wr         = 1'b0;
    ram_dout       = 8'd0;

    // A READ spends one extra cycle (cnt == len) capturing the final byte.
    active = (state != IDLE) && (cnt < len);
    if (active) begin
      ram_addr = base + {29'd0, cnt};
    end
    if (active && (state == WRITE) && owner_mem) begin
      ram_wr = 1'b1;
      case (cnt[1:0])
        2'd0:    ram_dout = wdata_q[7:0];
        2'd1:    ram_dout = wdata_q[15:8];
        2'd2:    ram_dout = wdata_q[23:16];
        default: ram_dout = wdata_q[31:24];
      endcase
    end

    case (state)
      IDLE: begin
        cnt_next = 3'd0;
        // The requester whose done is high in this cycle is still holding req.
        if (mem_req && !mem_done_q) begin
          owner_mem_next = 1'b1;
          base_next      = mem_addr;
          len_next       = len_of(mem_len);
          wdata_next     = mem_wdata;
          data_next      = 32'd0;
          state_next     = mem_we ? WRITE : READ;
        end else if (if_req && !if_done_q && !flush) begin
          owner_mem_next = 1'b0;
          base_next      = if_addr;
          len_next       = 3'd4;
          data_next      = 32'd0;
          state_next     = READ;
        end
      end

      READ: begin
        if (!owner_mem && flush) begin
          state_next = IDLE;
          cnt_next   = 3'd0;
          data_next  = 32'd0;
        end else begin
          case (cnt)
            3'd1:    data_next[7:0]   = ram_din;
            3'd2:    data_next[15:8]  = ram_din;
            3'd3:    data_next[23:16] = ram_din;
            3'd4:    data_next[31:24] = ram_din;
            default: ;
          endcase
          if (cnt == len) begin
            state_next = IDLE;
            cnt_next   = 3'd0;
            if (owner_mem) begin
              mem_done_next  = 1'b1;
              mem_rdata_next = data_next;
            end else begin
              if_done_next = 1'b1;
              if_inst_next = data_next;
            end
          end else begin
            cnt_next = cnt + 3'd1;
          end
        end
      end

      WRITE: begin
        if (cnt == len - 3'd1) begin
          state_next    = IDLE;
          cnt_next      = 3'd0;
          mem_done_next = 1'b1;
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // A redirect landing on the completion cycle discards the fetched word.
  assign if_done   = if_done_q & ~flush;
  assign if_inst   = if_inst_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = (state != IDLE);

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  one-cycle pulse, fetch complete
- if_inst  out  32  fetched word, valid while if_done=1
- mem_req  in  1  load/store request, held until mem_done
- mem_we  in  1  1=store, 0=load
- mem_len  in  2  0=byte, 1=half, 2 or 3=word
- mem_addr  in  32  load/store byte address
- mem_wdata  in  32  store data, little-endian
- mem_done  out  1  one-cycle pulse, load/store complete
- mem_rdata  out  32  load data, zero-filled above length, valid while mem_done=1
- flush  in  1  jump/branch redirect; cancels the fetch
- ram_addr  out  32  byte address to the single-port RAM
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte, valid the cycle after ram_addr
- busy  out  1  high in any state other than IDLE

Function
REQ-002 The FSM SHALL have the states IDLE, READ and WRITE, plus an owner flag (IF or MEM) and a 3-bit byte counter.
REQ-003 In IDLE, the FSM SHALL accept mem_req before if_req when both are high; mem_we=1 SHALL go to WRITE and mem_we=0 to READ.
REQ-004 An accepted transaction SHALL run to completion with no preemption; requests arriving meanwhile SHALL wait.
REQ-005 Transfer length N SHALL be 4 for a fetch, and 1, 2 or 4 for MEM according to mem_len.
REQ-006 The address, owner, length and write data SHALL be latched in the accept cycle A.
REQ-007 Byte i SHALL be addressed at base+i with 32-bit wrap-around, e.g. 0xFFFFFFFF+1 = 0x00000000.
REQ-008 READ: ram_addr SHALL equal base+i in cycle A+1+i, and ram_din SHALL be captured at the end of cycle A+2+i into bits [8i+7:8i].
REQ-009 READ: done SHALL be high in cycle A+N+2, giving a word latency of 6 cycles after accept.
REQ-010 WRITE: in cycle A+1+i, ram_addr=base+i, ram_wr=1 and ram_dout=wdata[8i+7:8i]; mem_done SHALL be high in cycle A+N+1.
REQ-011 In the done cycle the FSM SHALL be in IDLE and SHALL NOT accept the requester whose done is high; it MAY accept the other requester.
REQ-012 In IDLE, or in any cycle without an active byte, outputs SHALL be ram_wr=0, ram_addr=0 and ram_dout=0.
REQ-013 if_inst and mem_rdata SHALL hold their last values outside done cycles; unused upper bytes SHALL read as 0.
REQ-014 flush=1 during an IF-owned READ SHALL return the FSM to IDLE at the next edge with no if_done; bytes already captured SHALL be discarded.
REQ-015 flush=1 in IDLE SHALL block acceptance of if_req in that cycle; mem_req acceptance is unaffected.
REQ-016 flush=1 in an if_done cycle SHALL force if_done to 0.
REQ-017 flush SHALL have no effect on a MEM-owned transaction.
REQ-018 ram_wr SHALL never be 1 outside a MEM-owned WRITE.

Reset
REQ-019 rst=1 at a clock edge SHALL force IDLE, counter 0, and outputs if_done=0, mem_done=0, busy=0, ram_wr=0, ram_addr=0, ram_dout=0, if_inst=0, mem_rdata=0.
REQ-020 rst during a transaction SHALL abort it with no done pulse, and no ram_wr SHALL be issued after the reset edge.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Fetch: if_req, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 -> ram_addr 0x100..0x103 in A+1..A+4; if_done in A+6 with if_inst=0x00000513.
- Store half: mem_req, mem_we=1, mem_len=1, addr=0x2000, wdata=0xDEADBEEF -> ram_wr at 0x2000=EF in A+1 and 0x2001=BE in A+2; mem_done in A+3.
- Contention: if_req and mem_req (load byte at 0x30 = 0x80) in the same cycle -> MEM served first with mem_rdata=0x00000080 at A+3; fetch accepted next, if_done 6 cycles after its accept.
- Flush: fetch accepted, flush=1 in A+2 -> IDLE next cycle, no if_done; a new fetch at 0x200 completes normally.
- Wrap: load word at 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- Reset: rst=1 in A+2 of a word store -> only bytes 0 and 1 written, no mem_done, busy=0 after the edge.
